tc_pl_cap_gain_mgr: RTL and testbench
=====================================

TC_PL_CAP_GAIN_MGR -- requirements
Module: tc_pl_cap_gain_mgr

Interface
REQ-001 Parameters SHALL be: GAIN_NUM, default 8, number of gain table entries (2..16); GSEL_W, default 3, gain select width (GSEL_W = clog2(GAIN_NUM)); DAC_W, default 32, DAC word width; LMH_W, default 6, LMH code width; RLY_W, default 4, relay code width; DEL_W, default 32, settle and timeout counter width.
REQ-002 Ports, in order: name, direction, width, meaning.
  clk  in  1  sole clock.
  rst  in  1  asynchronous, active-low reset.
  gain_value  in  GSEL_W  requested gain index.
  gain_en  in  1  level request; deassertion aborts the sequence.
  gain_cmpt  out  1  high while a settled gain is applied.
  gain_err  out  1  high on a failed sequence.
  gain_cur  out  GSEL_W  last successfully applied index.
  cap_gain_del  in  DEL_W  settle cycles.
  cap_gain_tmo  in  DEL_W  completion timeout cycles.
  cap_dacA_tbl, cap_dacB_tbl  in  GAIN_NUM*DAC_W  flattened DAC tables; entry k = bits [k*DAC_W +: DAC_W].
  cap_lmh_tbl  in  GAIN_NUM*LMH_W  flattened LMH table.
  cap_relay_tbl  in  GAIN_NUM*RLY_W  flattened relay table.
  gset_en  out  1  programming request to the sub-blocks.
  gset_adc_cmpt, gset_lmh_cmpt, gset_relay_cmpt  in  1 each  sub-block done flags.
  gset_dacA, gset_dacB  out  DAC_W  selected DAC words.
  gset_lmh  out  LMH_W  selected LMH code.
  gset_relay  out  RLY_W  selected relay code.

Function
REQ-003 The FSM SHALL have states S_IDLE, S_LOAD, S_GSET, S_GDEL, S_CMPT and S_ERR.
REQ-004 S_IDLE: on gain_en=1, gain_value SHALL be captured into sel_q and the FSM SHALL enter S_LOAD.
REQ-005 S_LOAD, one cycle, SHALL:
  - if sel_q >= GAIN_NUM: enter S_ERR, with outputs unchanged;
  - else if sel_q == gain_cur and the valid flag (cur_vld) = 1: enter S_CMPT directly (same-gain fast path, no reprogramming);
  - else: register the table entry sel_q onto gset_dacA, gset_dacB, gset_lmh and gset_relay, set gset_en=1 and enter S_GSET.
REQ-006 S_GSET SHALL latch each of the three done flags into a sticky bit independently; when all three sticky bits are set, it SHALL clear gset_en and enter S_GDEL on the next edge. Done flags are not required to be simultaneous.
REQ-007 S_GDEL SHALL start its counter at 0 and increment every cycle, and SHALL exit to S_CMPT when count >= cap_gain_del. Residency is therefore cap_gain_del+1 cycles; cap_gain_del=0 gives 1 cycle.
REQ-008 On entry to S_CMPT: gain_cmpt=1, gain_cur=sel_q, cur_vld=1. The FSM SHALL hold in S_CMPT while gain_en=1.
REQ-009 In S_ERR, gain_err SHALL be 1 and gset_en SHALL be 0; the FSM SHALL hold in S_ERR while gain_en=1.
REQ-010 gain_en=0 in any state SHALL, on the next edge, force S_IDLE and clear gain_cmpt, gain_err, gset_en, the sticky bits and the counters; gset_* data and gain_cur SHALL be retained.
REQ-011 Aborting from S_GSET or S_GDEL SHALL clear cur_vld, because the hardware state is indeterminate.
REQ-012 A gain_value change while gain_en=1 SHALL be ignored until gain_en is cycled low.
REQ-013 Done flags asserted outside S_GSET SHALL be ignored.

Reset
REQ-014 rst=0 SHALL asynchronously force: state S_IDLE; gain_cmpt, gain_err and gset_en to 0; gset_dacA, gset_dacB, gset_lmh and gset_relay to 0; gain_cur to 0; cur_vld to 0; all counters and sticky bits to 0.
REQ-015 Reset deassertion SHALL be taken synchronously by the first clk edge after rst rises; no output SHALL glitch high on release.

Configuration
REQ-016 With macro CAP_GAIN_TMO_EN defined, S_GSET SHALL count cycles from entry; when count >= cap_gain_tmo without all three sticky bits set, it SHALL clear gset_en, clear cur_vld and enter S_ERR.
REQ-017 Without CAP_GAIN_TMO_EN, S_GSET SHALL wait indefinitely. The cap_gain_tmo port SHALL remain but be ignored, and gain_err SHALL assert only for an out-of-range index.

Verification
REQ-018 gain_value=2, gain_en=1; done flags at +3, +5 and +7 cycles after gset_en; cap_gain_del=4 -> gset_* = entry 2, gset_en falls 1 cycle after the last flag, gain_cmpt rises 5 cycles later, gain_cur=2.
REQ-019 Repeat of REQ-018 after a gain_en low cycle, same gain_value=2 -> gset_en never asserts, gain_cmpt=1 two cycles after gain_en rises.
REQ-020 GAIN_NUM=6, gain_value=7 -> gain_err=1 two cycles after gain_en, gset_en stays 0, outputs unchanged.
REQ-021 CAP_GAIN_TMO_EN defined, cap_gain_tmo=10, gset_lmh_cmpt never asserted -> gain_err=1 and gset_en=0 after 11 cycles in S_GSET, cur_vld=0; next request for the same gain reprograms.
REQ-022 gain_en dropped mid-S_GDEL -> gain_cmpt stays 0, FSM returns to S_IDLE, cur_vld=0.
REQ-023 rst asserted mid-S_GSET with no clock edge -> all outputs 0 immediately; first request after release performs a full reprogram.

Source files
------------

// File: rtl/tc_pl_cap_gain_mgr.sv
// -----------------------------------------------------------------------------
// tc_pl_cap_gain_mgr
//
// Capture-path gain manager. A level request (gain_en) selects an entry from
// the flattened DAC/LMH/relay tables. The entry is driven onto the gset_*
// outputs, and the manager waits for the three sub-blocks to report done. It
// then waits a programmable settle time before it reports gain_cmpt.
// Re-requesting the gain that is already applied and known-good skips the
// reprogramming.
//
// Optional build macro:
//   CAP_GAIN_TMO_EN - bound the wait for sub-block done flags by cap_gain_tmo
//                     cycles; on expiry enter the error state. When undefined,
//                     the wait is unbounded and cap_gain_tmo is ignored.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   gain_value, gain_en        requested index, level request (low = abort)
//   gain_cmpt, gain_err        settled-gain flag, failed-sequence flag
//   gain_cur                   last successfully applied index
//   cap_gain_del, cap_gain_tmo settle cycles, done-flag timeout cycles
//   cap_*_tbl                  flattened tables, entry k at [k*W +: W]
//   gset_en                    programming request to the sub-blocks
//   gset_*_cmpt                sub-block done flags
//   gset_dacA/B, gset_lmh,
//   gset_relay                 selected table entry
// -----------------------------------------------------------------------------
module tc_pl_cap_gain_mgr #(
  parameter int GAIN_NUM = 8,
  parameter int GSEL_W   = 3,
  parameter int DAC_W    = 32,
  parameter int LMH_W    = 6,
  parameter int RLY_W    = 4,
  parameter int DEL_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [GSEL_W-1:0]         gain_value,
  input  logic                      gain_en,
  output logic                      gain_cmpt,
  output logic                      gain_err,
  output logic [GSEL_W-1:0]         gain_cur,
  input  logic [DEL_W-1:0]          cap_gain_del,
  input  logic [DEL_W-1:0]          cap_gain_tmo,
  input  logic [GAIN_NUM*DAC_W-1:0] cap_dacA_tbl,
  input  logic [GAIN_NUM*DAC_W-1:0] cap_dacB_tbl,
  input  logic [GAIN_NUM*LMH_W-1:0] cap_lmh_tbl,
  input  logic [GAIN_NUM*RLY_W-1:0] cap_relay_tbl,
  output logic                      gset_en,
  input  logic                      gset_adc_cmpt,
  input  logic                      gset_lmh_cmpt,
  input  logic                      gset_relay_cmpt,
  output logic [DAC_W-1:0]          gset_dacA,
  output logic [DAC_W-1:0]          gset_dacB,
  output logic [LMH_W-1:0]          gset_lmh,
  output logic [RLY_W-1:0]          gset_relay
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GSET, S_GDEL, S_CMPT, S_ERR} state_t;

  localparam int                TBL_N     = 2 ** GSEL_W;
  localparam logic [GSEL_W:0]   GAIN_NUM_C = GAIN_NUM[GSEL_W:0];

  state_t              state, state_nxt;
  logic [GSEL_W-1:0]   sel_q, sel_nxt;
  logic                cur_vld, vld_nxt;
  logic [2:0]          sticky, sticky_nxt;
  logic [DEL_W-1:0]    cnt, cnt_nxt;
  logic                cmpt_nxt, err_nxt, gset_en_nxt;
  logic [GSEL_W-1:0]   cur_nxt;
  logic [DAC_W-1:0]    dacA_nxt, dacB_nxt;
  logic [LMH_W-1:0]    lmh_nxt;
  logic [RLY_W-1:0]    rly_nxt;
  logic [2:0]          done_now;
  logic                all_done;
  logic                sel_oor;

  // Unpack the tables into arrays covering the full select range, so any
  // sel_q value indexes a real element; unused slots read as zero.
  logic [DAC_W-1:0] dacA_ent [TBL_N];
  logic [DAC_W-1:0] dacB_ent [TBL_N];
  logic [LMH_W-1:0] lmh_ent  [TBL_N];
  logic [RLY_W-1:0] rly_ent  [TBL_N];

  for (genvar k = 0; k < TBL_N; k++) begin : g_tbl
    if (k < GAIN_NUM) begin : g_used
      assign dacA_ent[k] = cap_dacA_tbl[k*DAC_W +: DAC_W];
      assign dacB_ent[k] = cap_dacB_tbl[k*DAC_W +: DAC_W];
      assign lmh_ent[k]  = cap_lmh_tbl[k*LMH_W +: LMH_W];
      assign rly_ent[k]  = cap_relay_tbl[k*RLY_W +: RLY_W];
    end else begin : g_pad
      assign dacA_ent[k] = '0;
      assign dacB_ent[k] = '0;
      assign lmh_ent[k]  = '0;
      assign rly_ent[k]  = '0;
    end
  end

`ifndef CAP_GAIN_TMO_EN
  logic unused_tmo;
  assign unused_tmo = ^cap_gain_tmo;
`endif

  assign sel_oor  = ({1'b0, sel_q} >= GAIN_NUM_C);
  assign done_now = {gset_adc_cmpt, gset_lmh_cmpt, gset_relay_cmpt};
  // A flag arriving this cycle completes the set without waiting for it to
  // appear in the sticky register first.
  assign all_done = &(sticky | done_now);

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel_q;
    vld_nxt     = cur_vld;
    sticky_nxt  = sticky;
    cnt_nxt     = cnt;
    cmpt_nxt    = gain_cmpt;
    err_nxt     = gain_err;
    gset_en_nxt = gset_en;
    cur_nxt     = gain_cur;
    dacA_nxt    = gset_dacA;
    dacB_nxt    = gset_dacB;
    lmh_nxt     = gset_lmh;
    rly_nxt     = gset_relay;

    if (!gain_en) begin
      state_nxt   = S_IDLE;
      cmpt_nxt    = 1'b0;
      err_nxt     = 1'b0;
      gset_en_nxt = 1'b0;
      sticky_nxt  = '0;
      cnt_nxt     = '0;
      // Sub-blocks may be half-programmed, so the applied gain is unknown.
      if (state == S_GSET || state == S_GDEL) vld_nxt = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          sel_nxt   = gain_value;
          state_nxt = S_LOAD;
        end
        S_LOAD: begin
          if (sel_oor) begin
            err_nxt   = 1'b1;
            state_nxt = S_ERR;
          end else if (sel_q == gain_cur && cur_vld) begin
            cmpt_nxt  = 1'b1;
            state_nxt = S_CMPT;
          end else begin
            dacA_nxt    = dacA_ent[sel_q];
            dacB_nxt    = dacB_ent[sel_q];
            lmh_nxt     = lmh_ent[sel_q];
            rly_nxt     = rly_ent[sel_q];
            gset_en_nxt = 1'b1;
            sticky_nxt  = '0;
            cnt_nxt     = '0;
            state_nxt   = S_GSET;
          end
        end
        S_GSET: begin
          sticky_nxt = sticky | done_now;
          if (all_done) begin
            gset_en_nxt = 1'b0;
            sticky_nxt  = '0;
            cnt_nxt     = '0;
            state_nxt   = S_GDEL;
          end
`ifdef CAP_GAIN_TMO_EN
          else if (cnt >= cap_gain_tmo) begin
            gset_en_nxt = 1'b0;
            vld_nxt     = 1'b0;
            err_nxt     = 1'b1;
            sticky_nxt  = '0;
            cnt_nxt     = '0;
            state_nxt   = S_ERR;
          end else begin
            cnt_nxt = cnt + DEL_W'(1);
          end
`endif
        end
        S_GDEL: begin
          if (cnt >= cap_gain_del) begin
            cmpt_nxt  = 1'b1;
            cur_nxt   = sel_q;
            vld_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = S_CMPT;
          end else begin
            cnt_nxt = cnt + DEL_W'(1);
          end
        end
        S_CMPT: state_nxt = S_CMPT;
        S_ERR:  state_nxt = S_ERR;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q      <= '0;
      cur_vld    <= 1'b0;
      sticky     <= '0;
      cnt        <= '0;
      gain_cmpt  <= 1'b0;
      gain_err   <= 1'b0;
      gset_en    <= 1'b0;
      gain_cur   <= '0;
      gset_dacA  <= '0;
      gset_dacB  <= '0;
      gset_lmh   <= '0;
      gset_relay <= '0;
    end else begin
      sel_q      <= sel_nxt;
      cur_vld    <= vld_nxt;
      sticky     <= sticky_nxt;
      cnt        <= cnt_nxt;
      gain_cmpt  <= cmpt_nxt;
      gain_err   <= err_nxt;
      gset_en    <= gset_en_nxt;
      gain_cur   <= cur_nxt;
      gset_dacA  <= dacA_nxt;
      gset_dacB  <= dacB_nxt;
      gset_lmh   <= lmh_nxt;
      gset_relay <= rly_nxt;
    end
  end

endmodule

// File: tb/tb_tc_pl_cap_gain_mgr.sv
// -----------------------------------------------------------------------------
// tb_tc_pl_cap_gain_mgr
//
// Directed bench for tc_pl_cap_gain_mgr. A table of request records (index,
// done-flag arrival offsets, settle count, expected entry and timing) is
// replayed cycle by cycle, followed by hand-written sequences for the
// out-of-range index (GAIN_NUM=6 instance), abort during settle, done-flag
// timeout or unbounded wait, and asynchronous reset mid-programming.
// -----------------------------------------------------------------------------
module tb_tc_pl_cap_gain_mgr;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   gain_value;
  logic         gain_en;
  logic         gain_cmpt, gain_err;
  logic [2:0]   gain_cur;
  logic [31:0]  cap_gain_del, cap_gain_tmo;
  logic [255:0] dacA_tbl, dacB_tbl;
  logic [47:0]  lmh_tbl;
  logic [31:0]  rly_tbl;
  logic         gset_en;
  logic         adc_cmpt, lmh_cmpt, rly_cmpt;
  logic [31:0]  gset_dacA, gset_dacB;
  logic [5:0]   gset_lmh;
  logic [3:0]   gset_relay;

  logic [2:0]   g6_value;
  logic         g6_en;
  logic         g6_cmpt, g6_err, g6_gset_en;
  logic [2:0]   g6_cur;
  logic [31:0]  g6_dacA, g6_dacB;
  logic [5:0]   g6_lmh;
  logic [3:0]   g6_relay;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tc_pl_cap_gain_mgr dut (
    .clk(clk), .rst(rst), .gain_value(gain_value), .gain_en(gain_en),
    .gain_cmpt(gain_cmpt), .gain_err(gain_err), .gain_cur(gain_cur),
    .cap_gain_del(cap_gain_del), .cap_gain_tmo(cap_gain_tmo),
    .cap_dacA_tbl(dacA_tbl), .cap_dacB_tbl(dacB_tbl),
    .cap_lmh_tbl(lmh_tbl), .cap_relay_tbl(rly_tbl),
    .gset_en(gset_en), .gset_adc_cmpt(adc_cmpt), .gset_lmh_cmpt(lmh_cmpt),
    .gset_relay_cmpt(rly_cmpt), .gset_dacA(gset_dacA), .gset_dacB(gset_dacB),
    .gset_lmh(gset_lmh), .gset_relay(gset_relay)
  );

  tc_pl_cap_gain_mgr #(.GAIN_NUM(6)) dut6 (
    .clk(clk), .rst(rst), .gain_value(g6_value), .gain_en(g6_en),
    .gain_cmpt(g6_cmpt), .gain_err(g6_err), .gain_cur(g6_cur),
    .cap_gain_del(cap_gain_del), .cap_gain_tmo(cap_gain_tmo),
    .cap_dacA_tbl(dacA_tbl[191:0]), .cap_dacB_tbl(dacB_tbl[191:0]),
    .cap_lmh_tbl(lmh_tbl[35:0]), .cap_relay_tbl(rly_tbl[23:0]),
    .gset_en(g6_gset_en), .gset_adc_cmpt(1'b0), .gset_lmh_cmpt(1'b0),
    .gset_relay_cmpt(1'b0), .gset_dacA(g6_dacA), .gset_dacB(g6_dacB),
    .gset_lmh(g6_lmh), .gset_relay(g6_relay)
  );

  typedef struct {
    logic [2:0]  gv;
    int          d_adc, d_lmh, d_rly;  // flag offset in cycles after gset_en rises
    int          del;
    bit          fast;                 // same-gain fast path expected
    int          gset_hi;              // cycles gset_en stays high
    int          lat;                  // edges from request to gain_cmpt
    logic [31:0] exp_dacA, exp_dacB;
    logic [5:0]  exp_lmh;
    logic [3:0]  exp_rly;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0b, expected %0b", name, idx, act, exp);
    end
  endtask

  task automatic chkv(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    cap_gain_del = 32'(v.del);
    gain_value   = v.gv;
    gain_en      = 1'b1;
    for (int k = 1; k <= v.lat; k++) begin
      tick();
      if (k == 1) gain_value = ~v.gv;  // must be ignored while gain_en is high
      adc_cmpt = (k == 2 + v.d_adc);
      lmh_cmpt = (k == 2 + v.d_lmh);
      rly_cmpt = (k == 2 + v.d_rly);
      chk1("gset_en", idx*100 + k, gset_en, !v.fast && k >= 2 && k <= 1 + v.gset_hi);
      chk1("gain_cmpt", idx*100 + k, gain_cmpt, k >= v.lat);
    end
    chkv("gain_cur", idx, 64'(gain_cur), 64'(v.gv));
    chkv("gset_dacA", idx, 64'(gset_dacA), 64'(v.exp_dacA));
    chkv("gset_dacB", idx, 64'(gset_dacB), 64'(v.exp_dacB));
    chkv("gset_lmh", idx, 64'(gset_lmh), 64'(v.exp_lmh));
    chkv("gset_relay", idx, 64'(gset_relay), 64'(v.exp_rly));
    chk1("gain_err", idx, gain_err, 1'b0);
    gain_en  = 1'b0;
    adc_cmpt = 1'b0;
    lmh_cmpt = 1'b0;
    rly_cmpt = 1'b0;
    tick();
    chk1("drop_cmpt", idx, gain_cmpt, 1'b0);
    chkv("drop_cur", idx, 64'(gain_cur), 64'(v.gv));
  endtask

  // Request an index expected to reprogram, all flags at once, settle 0.
  task automatic full_prog(input logic [2:0] gv, input int idx);
    cap_gain_del = 32'd0;
    gain_value   = gv;
    gain_en      = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      adc_cmpt = (k == 2);
      lmh_cmpt = (k == 2);
      rly_cmpt = (k == 2);
      if (k == 2) begin
        chk1("reprog_gset_en", idx, gset_en, 1'b1);
        chkv("reprog_lmh", idx, 64'(gset_lmh), 64'(6'(gv) + 6'd8));
      end
    end
    chk1("reprog_cmpt", idx, gain_cmpt, 1'b1);
    chkv("reprog_cur", idx, 64'(gain_cur), 64'(gv));
    gain_en = 1'b0;
    tick();
  endtask

  vec_t vt[7];

  initial begin
    for (int k = 0; k < 8; k++) begin
      dacA_tbl[k*32 +: 32] = 32'hA0A0_0000 + 32'(k);
      dacB_tbl[k*32 +: 32] = 32'hB0B0_0000 + 32'(k);
      lmh_tbl[k*6 +: 6]    = 6'(k + 8);
      rly_tbl[k*4 +: 4]    = 4'(15 - k);
    end
    //          gv    adc lmh rly del fast hi lat  dacA          dacB          lmh rly
    vt[0] = '{3'd2, 3,  5,  7,  4,  1'b0, 8, 15, 32'hA0A00002, 32'hB0B00002, 6'd10, 4'd13};
    vt[1] = '{3'd2, 0,  0,  0,  4,  1'b1, 0, 2,  32'hA0A00002, 32'hB0B00002, 6'd10, 4'd13};
    vt[2] = '{3'd5, 0,  0,  0,  0,  1'b0, 1, 4,  32'hA0A00005, 32'hB0B00005, 6'd13, 4'd10};
    vt[3] = '{3'd7, 4,  1,  1,  2,  1'b0, 5, 10, 32'hA0A00007, 32'hB0B00007, 6'd15, 4'd8};
    vt[4] = '{3'd0, 2,  6,  0,  1,  1'b0, 7, 11, 32'hA0A00000, 32'hB0B00000, 6'd8,  4'd15};
    vt[5] = '{3'd0, 0,  0,  0,  1,  1'b1, 0, 2,  32'hA0A00000, 32'hB0B00000, 6'd8,  4'd15};
    vt[6] = '{3'd7, 1,  1,  1,  0,  1'b0, 2, 5,  32'hA0A00007, 32'hB0B00007, 6'd15, 4'd8};

    // Reset holds everything at zero even with a request pending.
    rst = 1'b0; gain_en = 1'b1; gain_value = 3'd3; g6_en = 1'b0; g6_value = 3'd0;
    adc_cmpt = 1'b0; lmh_cmpt = 1'b0; rly_cmpt = 1'b0;
    cap_gain_del = 32'd0; cap_gain_tmo = 32'd10;
    tick(); tick();
    chk1("rst_cmpt", 0, gain_cmpt, 1'b0);
    chk1("rst_err", 0, gain_err, 1'b0);
    chk1("rst_gset_en", 0, gset_en, 1'b0);
    chkv("rst_cur", 0, 64'(gain_cur), 64'd0);
    chkv("rst_dacA", 0, 64'(gset_dacA), 64'd0);
    chkv("rst_lmh", 0, 64'(gset_lmh), 64'd0);
    gain_en = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk1("rel_gset_en", 0, gset_en, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Out-of-range and last valid index on the six-entry instance.
    g6_value = 3'd7; g6_en = 1'b1;
    tick(); tick();
    chk1("oor7_err", 0, g6_err, 1'b1);
    chk1("oor7_gset_en", 0, g6_gset_en, 1'b0);
    chkv("oor7_lmh", 0, 64'(g6_lmh), 64'd0);
    chkv("oor7_cur", 0, 64'(g6_cur), 64'd0);
    tick(); tick(); tick();
    chk1("oor7_hold", 0, g6_err, 1'b1);
    chk1("oor7_cmpt", 0, g6_cmpt, 1'b0);
    g6_en = 1'b0;
    tick();
    chk1("oor7_drop", 0, g6_err, 1'b0);
    g6_value = 3'd6; g6_en = 1'b1;
    tick(); tick();
    chk1("oor6_err", 0, g6_err, 1'b1);
    chk1("oor6_gset_en", 0, g6_gset_en, 1'b0);
    g6_en = 1'b0;
    tick();
    g6_value = 3'd5; g6_en = 1'b1;
    tick(); tick();
    chk1("last_err", 0, g6_err, 1'b0);
    chk1("last_gset_en", 0, g6_gset_en, 1'b1);
    chkv("last_lmh", 0, 64'(g6_lmh), 64'd13);
    chkv("last_dacA", 0, 64'(g6_dacA), 64'hA0A00005);
    g6_en = 1'b0;
    tick();
    chk1("last_drop", 0, g6_gset_en, 1'b0);
    chkv("last_keep", 0, 64'(g6_lmh), 64'd13);

    // Abort during settle: nothing completes, gain 7 is no longer trusted.
    cap_gain_del = 32'd10; gain_value = 3'd3; gain_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      adc_cmpt = (k == 2); lmh_cmpt = (k == 2); rly_cmpt = (k == 2);
      if (k == 3) chk1("gdel_gset_en", 0, gset_en, 1'b0);
    end
    chk1("gdel_cmpt", 0, gain_cmpt, 1'b0);
    gain_en = 1'b0;
    tick();
    chk1("abort_cmpt", 0, gain_cmpt, 1'b0);
    chk1("abort_gset_en", 0, gset_en, 1'b0);
    chkv("abort_lmh", 0, 64'(gset_lmh), 64'd11);
    chkv("abort_cur", 0, 64'(gain_cur), 64'd7);
    full_prog(3'd7, 1);

    // Gain 7 is valid again; request 1 with the LMH flag never arriving.
    gain_value = 3'd1; gain_en = 1'b1;
`ifdef CAP_GAIN_TMO_EN
    for (int k = 1; k <= 15; k++) begin
      tick();
      adc_cmpt = (k == 2); rly_cmpt = (k == 2);
      if (k == 12) begin
        chk1("tmo_pre_gset_en", 0, gset_en, 1'b1);
        chk1("tmo_pre_err", 0, gain_err, 1'b0);
      end
      if (k == 13) begin
        chk1("tmo_err", 0, gain_err, 1'b1);
        chk1("tmo_gset_en", 0, gset_en, 1'b0);
      end
      if (k == 15) chk1("tmo_hold", 0, gain_err, 1'b1);
    end
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      adc_cmpt = (k == 2); rly_cmpt = (k == 2);
    end
    chk1("wait_gset_en", 0, gset_en, 1'b1);
    chk1("wait_err", 0, gain_err, 1'b0);
    chk1("wait_cmpt", 0, gain_cmpt, 1'b0);
`endif
    gain_en = 1'b0; adc_cmpt = 1'b0; rly_cmpt = 1'b0;
    tick();
    chk1("fail_drop_err", 0, gain_err, 1'b0);
    chk1("fail_drop_gset", 0, gset_en, 1'b0);
    full_prog(3'd7, 2);

    // Asynchronous reset while programming gain 4.
    gain_value = 3'd4; gain_en = 1'b1;
    tick(); tick(); tick();
    chk1("pre_rst_gset_en", 0, gset_en, 1'b1);
    rst = 1'b0;
    #2;
    chk1("arst_gset_en", 0, gset_en, 1'b0);
    chk1("arst_cmpt", 0, gain_cmpt, 1'b0);
    chk1("arst_err", 0, gain_err, 1'b0);
    chkv("arst_cur", 0, 64'(gain_cur), 64'd0);
    chkv("arst_lmh", 0, 64'(gset_lmh), 64'd0);
    chkv("arst_dacB", 0, 64'(gset_dacB), 64'd0);
    chkv("arst_relay", 0, 64'(gset_relay), 64'd0);
    gain_en = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk1("rel2_gset_en", 0, gset_en, 1'b0);
    tick();
    full_prog(3'd0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
